// File: rtl/alu_pkg.sv
// alu_pkg: shared states, default sizes and index-width helper for the serial subtractor.
package alu_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} sub_state_t;
    localparam int WIDTH_DEF   = 16;
    localparam int SLICE_DEF   = 4;
    localparam int NSLICES_DEF = WIDTH_DEF / SLICE_DEF;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    localparam int IDX_W = idx_w(NSLICES_DEF);
endpackage

// File: rtl/subtract_slice4.sv
// subtract_slice4: combinational 4-bit a + ~b + cin as a chain of 1-bit full adders.
module subtract_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ ~b[i] ^ c[i];
        assign c[i+1] = (a[i] & ~b[i]) | (c[i] & (a[i] ^ ~b[i]));
    end
    assign cout = c[4];
endmodule

// File: rtl/nibble_serial_subtractor16.sv
// nibble_serial_subtractor16: a - b - bin computed one 4-bit slice per clock, LSB slice first,
// with valid/ready handshakes on both sides and registered compare flags.
module nibble_serial_subtractor16
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);
    localparam int NSLICES = WIDTH / SLICE;
    localparam int IW = idx_w(NSLICES);

    sub_state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic [IW-1:0] idx_q, idx_d;
    logic carry_q, carry_d, bout_q, bout_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
    logic [SLICE-1:0] s;
    logic cout;

    subtract_slice4 u_slice (
        .a   (a_q[idx_q*SLICE +: SLICE]),
        .b   (b_q[idx_q*SLICE +: SLICE]),
        .cin (carry_q),
        .s   (s),
        .cout(cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = BUSY;
                a_d     = a;
                b_d     = b;
                carry_d = ~bin;
                idx_d   = '0;
            end
            BUSY: begin
                diff_d[idx_q*SLICE +: SLICE] = s;
                carry_d = cout;
                idx_d   = idx_q + 1'b1;
                // Flags are taken from the completed word including the slice written this edge
                if (idx_q == IW'(NSLICES - 1)) begin
                    state_d = DONE;
                    bout_d  = ~cout;
                    zero_d  = (diff_d == '0);
                    neg_d   = diff_d[WIDTH-1];
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_subtractor16.sv
// tb_nibble_serial_subtractor16: directed and random operations checked against an arithmetic model.
module tb_nibble_serial_subtractor16;
    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, out_ready = 1'b0, bin = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic in_ready, out_valid, bout, zero, neg, ovf;
    logic [15:0] diff;
    int passed = 0, failed = 0, total = 0;

    nibble_serial_subtractor16 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .zero(zero), .neg(neg), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {bout, zero, neg, ovf, diff} from plain 17-bit arithmetic
    function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y, input logic bi);
        logic [16:0] r;
        r = {1'b0, x} - {1'b0, y} - {16'b0, bi};
        return {r[16], r[15:0] == 16'h0, r[15], (x[15] != y[15]) && (r[15] != x[15]), r[15:0]};
    endfunction

    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic bi, input int hold);
        logic [19:0] m;
        m = model(x, y, bi);
        @(negedge clk);
        a = x; b = y; bin = bi; in_valid = 1'b1;
        chk("in_ready_before", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("busy_out_valid", {31'b0, out_valid}, 32'd0);
            chk("busy_in_ready", {31'b0, in_ready}, 32'd0);
            in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
            out_ready = 1'($urandom);
            if (i == 3) begin in_valid = 1'b0; out_ready = 1'b0; end
            @(negedge clk);
        end
        for (int h = 0; h <= hold; h++) begin
            chk("out_valid", {31'b0, out_valid}, 32'd1);
            chk("diff", {16'b0, diff}, {16'b0, m[15:0]});
            chk("flags", {28'b0, bout, zero, neg, ovf}, {28'b0, m[19:16]});
            if (h < hold) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("after_out_valid", {31'b0, out_valid}, 32'd0);
        chk("after_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_outputs", {12'b0, diff, bout, zero, neg, ovf}, 32'd0);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        do_op(16'd24, 16'd12, 1'b0, 0);
        do_op(16'd12, 16'd24, 1'b0, 0);
        do_op(16'h8000, 16'd1, 1'b0, 0);
        do_op(16'd7866, 16'd7866, 1'b0, 0);
        do_op(16'h0000, 16'hFFFF, 1'b1, 0);
        do_op(16'h7FFF, 16'hFFFF, 1'b0, 10);
        do_op(16'h8000, 16'h0000, 1'b1, 0);
        // Abort on the second BUSY cycle
        @(negedge clk);
        a = 16'd500; b = 16'd3; bin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd0);
        chk("abort_outputs", {12'b0, diff, bout, zero, neg, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("abort_release_in_ready", {31'b0, in_ready}, 32'd1);
        do_op(16'd100, 16'd58, 1'b0, 0);
        for (int n = 0; n < 30; n++)
            do_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
